// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding, bus width defaults and lane helper
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;
   localparam int BPW            = APB_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      APB_IDLE,
      APB_SETUP,
      APB_ACCESS
   } apb_state_e;

   // Number of byte-offset bits below the word index for a given data width.
   function automatic int lane_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// rtl/apb_slv_wait_ctr.sv - loadable 4-bit down-counter pacing ACCESS wait states
module apb_slv_wait_ctr (
   input  logic       pclock,
   input  logic       presetn,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [3:0] cnt;

   // Load wins over decrement; decrement holds at zero so done stays asserted.
   always_ff @(posedge pclock or negedge presetn) begin
      if (!presetn) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign done = (cnt == 4'd0);

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a word-addressed flop memory
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                  pclock,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int LSB = lane_bits(DATA_WIDTH);
   localparam int WW  = ADDR_WIDTH - LSB;
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   apb_state_e            state;
   apb_state_e            state_next;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  capture;
   logic                  ctr_dec;
   logic                  done;
   logic                  err;
   logic                  complete;
   logic [WW-1:0]         word;
   logic [IW-1:0]         idx;

   // Decode works only from latched address so bus changes during ACCESS are harmless.
   assign word     = addr_q[ADDR_WIDTH-1:LSB];
   assign idx      = word[IW-1:0];
   assign err      = (addr_q[LSB-1:0] != '0) || (word >= WW'(DEPTH));
   assign complete = (state == APB_ACCESS) && done;

   assign pready  = complete;
   assign pslverr = complete && err;
   assign prdata  = (complete && !wr_q && !err) ? mem[idx] : '0;

   apb_slv_wait_ctr u_wait_ctr (
      .pclock   (pclock),
      .presetn  (presetn),
      .load     (capture),
      .load_val (4'(WAIT_STATES)),
      .dec      (ctr_dec),
      .done     (done)
   );

   // Next-state and counter control; a new setup may start in the completing cycle.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      ctr_dec    = 1'b0;
      case (state)
         APB_IDLE: begin
            if (psel && !penable) begin
               state_next = APB_SETUP;
               capture    = 1'b1;
            end
         end
         APB_SETUP: begin
            state_next = APB_ACCESS;
         end
         APB_ACCESS: begin
            if (done) begin
               if (psel && !penable) begin
                  state_next = APB_SETUP;
                  capture    = 1'b1;
               end else begin
                  state_next = APB_IDLE;
               end
            end else if (!psel) begin
               state_next = APB_IDLE;
            end else begin
               ctr_dec = 1'b1;
            end
         end
         default: begin
            state_next = APB_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge pclock or negedge presetn) begin
      if (!presetn) begin
         state <= APB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the transfer's address, direction and data at setup.
   always_ff @(posedge pclock or negedge presetn) begin
      if (!presetn) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else if (capture) begin
         addr_q  <= paddr;
         wr_q    <= pwrite;
         wdata_q <= pwdata;
      end
   end

   // Storage: written only on a clean completing write.
   always_ff @(posedge pclock or negedge presetn) begin
      if (!presetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (complete && wr_q && !err) begin
         mem[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - randomized self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

   localparam int NDUT = 3;
   localparam int WS [NDUT] = '{0, 2, 3};

   logic              pclock;
   logic              presetn;
   logic [NDUT-1:0]   psel_v;
   logic              penable;
   logic              pwrite;
   logic [31:0]       paddr;
   logic [31:0]       pwdata;
   logic [31:0]       rd [NDUT];
   logic [NDUT-1:0]   rdy;
   logic [NDUT-1:0]   serr;

   int total;
   int bad;
   bit presetup;

   logic [31:0] mdl [NDUT][16];

   int          cd;
   bit          cwr, nwr, ch;
   logic [31:0] ca, cdat, na, nd;

   initial pclock = 1'b0;
   always #5 pclock = ~pclock;

   apb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
      .pclock(pclock), .presetn(presetn), .psel(psel_v[0]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(rd[0]), .pready(rdy[0]), .pslverr(serr[0]));

   apb_slave_mem #(.WAIT_STATES(2)) u_ws2 (
      .pclock(pclock), .presetn(presetn), .psel(psel_v[1]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(rd[1]), .pready(rdy[1]), .pslverr(serr[1]));

   apb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
      .pclock(pclock), .presetn(presetn), .psel(psel_v[2]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(rd[2]), .pready(rdy[2]), .pslverr(serr[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit addr_err(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= 16);
   endfunction

   task automatic drive_setup(input int d, input bit w, input logic [31:0] a,
                              input logic [31:0] dv);
      psel_v    = '0;
      psel_v[d] = 1'b1;
      penable   = 1'b0;
      pwrite    = w;
      paddr     = a;
      pwdata    = dv;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NDUT; i++)
         for (int j = 0; j < 16; j++)
            mdl[i][j] = '0;
   endtask

   // One complete transfer on DUT d; optionally chains the next setup into the completing cycle.
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dv,
                       input bit chain, input bit nw, input logic [31:0] nadr,
                       input logic [31:0] ndat);
      bit e;
      e = addr_err(a);
      if (!presetup) begin
         @(negedge pclock);
         chk("idle_rdy", 32'(rdy[d]), 0);
         drive_setup(d, w, a, dv);
      end
      presetup = 1'b0;
      @(negedge pclock);
      chk("setup_rdy", 32'(rdy[d]), 0);
      penable = 1'b1;
      for (int k = 0; k < WS[d]; k++) begin
         @(negedge pclock);
         chk("wait_rdy", 32'(rdy[d]), 0);
         chk("wait_err", 32'(serr[d]), 0);
         chk("wait_rdata", rd[d], 0);
      end
      @(negedge pclock);
      chk("done_rdy", 32'(rdy[d]), 1);
      chk("done_err", 32'(serr[d]), 32'(e));
      if (!w) chk("rdata", rd[d], e ? 32'h0 : mdl[d][a[5:2]]);
      if (w && !e) mdl[d][a[5:2]] = dv;
      if (chain) begin
         drive_setup(d, nw, nadr, ndat);
         presetup = 1'b1;
      end else begin
         psel_v  = '0;
         penable = 1'b0;
      end
   endtask

   task automatic gen(output bit w, output logic [31:0] a, output logic [31:0] dv);
      w  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 'h4F));
      else                           a = 32'($urandom_range(0, 19)) * 4;
      dv = $urandom;
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      presetup = 1'b0;
      clear_model();
      presetn  = 1'b0;
      psel_v   = '0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pwdata   = '0;
      repeat (3) @(negedge pclock);
      for (int i = 0; i < NDUT; i++) begin
         chk("rst_rdy", 32'(rdy[i]), 0);
         chk("rst_err", 32'(serr[i]), 0);
         chk("rst_rdata", rd[i], 0);
      end
      presetn = 1'b1;

      // Basic write then read, zero wait states.
      xfer(0, 1, 32'h08, 32'hDEADBEEF, 0, 0, 0, 0);
      xfer(0, 0, 32'h08, 0, 0, 0, 0, 0);
      // Three wait states on a fresh word.
      xfer(2, 0, 32'h00, 0, 0, 0, 0, 0);
      // Out-of-range and unaligned accesses.
      xfer(0, 1, 32'h40, 32'h1234, 0, 0, 0, 0);
      xfer(0, 0, 32'h00, 0, 0, 0, 0, 0);
      xfer(0, 0, 32'h05, 0, 0, 0, 0, 0);
      xfer(0, 1, 32'h06, 32'h55555555, 0, 0, 0, 0);
      xfer(0, 0, 32'h04, 0, 0, 0, 0, 0);
      xfer(0, 0, 32'h08, 0, 0, 0, 0, 0);
      // Back-to-back write then read of the same word.
      xfer(0, 1, 32'h04, 32'hA5A5A5A5, 1, 0, 32'h04, 0);
      xfer(0, 0, 32'h04, 0, 0, 0, 0, 0);
      xfer(2, 1, 32'h10, 32'h0BADF00D, 1, 0, 32'h10, 0);
      xfer(2, 0, 32'h10, 0, 0, 0, 0, 0);

      // Dropping psel mid-wait abandons the write.
      @(negedge pclock);
      drive_setup(2, 1, 32'h14, 32'h00000777);
      @(negedge pclock);
      penable = 1'b1;
      @(negedge pclock);
      chk("abort_wait_rdy", 32'(rdy[2]), 0);
      psel_v  = '0;
      penable = 1'b0;
      @(negedge pclock);
      chk("abort_idle_rdy", 32'(rdy[2]), 0);
      xfer(2, 0, 32'h14, 0, 0, 0, 0, 0);

      // Reset during an ACCESS wait drops the write and clears storage.
      @(negedge pclock);
      drive_setup(1, 1, 32'h0C, 32'h0000FFFF);
      @(negedge pclock);
      penable = 1'b1;
      @(negedge pclock);
      chk("rstw_pre_rdy", 32'(rdy[1]), 0);
      presetn = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk("rstw_rdy", 32'(rdy[i]), 0);
         chk("rstw_err", 32'(serr[i]), 0);
         chk("rstw_rdata", rd[i], 0);
      end
      clear_model();
      psel_v  = '0;
      penable = 1'b0;
      @(negedge pclock);
      presetn = 1'b1;
      xfer(1, 0, 32'h0C, 0, 0, 0, 0, 0);
      xfer(0, 0, 32'h04, 0, 0, 0, 0, 0);
      xfer(2, 0, 32'h10, 0, 0, 0, 0, 0);

      // Randomized traffic with occasional back-to-back chaining.
      cd = $urandom_range(0, NDUT - 1);
      gen(cwr, ca, cdat);
      for (int i = 0; i < 120; i++) begin
         ch = ($urandom_range(0, 2) == 0) && (i != 119);
         gen(nwr, na, nd);
         xfer(cd, cwr, ca, cdat, ch, nwr, na, nd);
         if (ch) begin
            cwr  = nwr;
            ca   = na;
            cdat = nd;
         end else begin
            cd = $urandom_range(0, NDUT - 1);
            gen(cwr, ca, cdat);
         end
      end

      // Sweep every word of every DUT against the model.
      for (int d = 0; d < NDUT; d++)
         for (int j = 0; j < 16; j++)
            xfer(d, 0, 32'(j) * 4, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
